// File: rtl/muldiv_unit.sv
// Iterative RV32IM multiply/divide engine: shift-add multiply, restoring divide,
// fixed 34-cycle START-to-DONE latency with sign fix-up in a final FIX cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  state_t state, state_nxt;

  logic [2:0]        op;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   orig_a;
  logic              neg_main;
  logic              neg_rem;
  logic              div_zero;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  logic              a_signed, b_signed;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_word;
  logic              last_iter;

  assign last_iter = (cnt == CW'(XLEN - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; comb blocks use blocking assignments.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (last_iter) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_CALC, S_FIX: busy = 1'b1;
      S_DONE:        done = 1'b1;
      default: ;
    endcase
  end

  // Operand signedness: MUL only needs the low word, so it runs unsigned.
  always_comb begin
    a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
               (funct3 == F_DIV)  || (funct3 == F_REM);
    b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    a_neg    = a_signed & data1[XLEN-1];
    b_neg    = b_signed & data2[XLEN-1];
    a_mag    = a_neg ? (~data1 + 1'b1) : data1;
    b_mag    = b_neg ? (~data2 + 1'b1) : data2;
  end

  // One iteration of each algorithm; the multiplier sits in acc's low half.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_shift = {rem, quo[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
  end

  always_comb begin
    prod_fix = neg_main ? (~acc + 1'b1) : acc;
    quo_fix  = neg_main ? (~quo + 1'b1) : quo;
    rem_fix  = neg_rem  ? (~rem + 1'b1) : rem;
    fix_word = '0;
    case (op)
      F_MUL:                    fix_word = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: fix_word = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:            fix_word = div_zero ? '1 : quo_fix;
      F_REM, F_REMU:            fix_word = div_zero ? orig_a : rem_fix;
      default:                  fix_word = '0;
    endcase
  end

  // NOTE: datapath registers are reset too, so an aborted operation leaves
  // no stale partial state and reset values are deterministic.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op       <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      orig_a   <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      quo      <= '0;
      rem      <= '0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op       <= funct3;
            mag_a    <= a_mag;
            mag_b    <= b_mag;
            orig_a   <= data1;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (data2 == '0);
            cnt      <= '0;
            acc      <= {{XLEN{1'b0}}, b_mag};
            quo      <= a_mag;
            rem      <= '0;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (op[2]) begin
            // Remainder always stays below the divisor, so XLEN bits hold it.
            if (!div_diff[XLEN+1]) begin
              rem <= div_diff[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= div_shift[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end
        end
        S_FIX: result <= fix_word;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic results, fixed
// latency, BUSY/DONE framing, START hazards and asynchronous reset abort.
module tb_muldiv_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .funct3 (funct3),
    .data1  (data1),
    .data2  (data2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE; scramble inputs after acceptance.
  task automatic run_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int  n;
    int  nbusy;
    int  nboth;
    bit  seen;
    funct3 = f;
    data1  = a;
    data2  = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    funct3 = ~f;
    data1  = 32'hDEAD_BEEF;
    data2  = 32'h0000_0000;
    n = 0; nbusy = 0; nboth = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      if (busy) nbusy++;
      if (busy && done) nboth++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_result"}, result, exp);
    check({tag, "_latency"}, 32'(n + 1), 32'd34);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd33);
    check({tag, "_busy_done_overlap"}, 32'(nboth), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  int          nd;
  int          n;
  logic [31:0] res_q [3];
  int          edge_q [3];

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    funct3 = 3'b000;
    data1  = '0;
    data2  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0000_0000);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op("mul_6x3",        3'b000, 32'd6,         32'd3,         32'h0000_0012);
    run_op("mulh_m1xm1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("mulhu_max",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu_m1x2",    3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    run_op("mul_min_x_m1",   3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("div_m7_2",       3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op("rem_m7_2",       3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op("divu_big_2",     3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC);
    run_op("remu_big_2",     3'b111, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001);
    run_op("div_by_zero",    3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    run_op("divu_by_zero",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_op("rem_by_zero",    3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    run_op("div_overflow",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_overflow",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // START held high: accepts land on edges 0, 35 and 70.
    funct3 = 3'b000;
    data2  = 32'd3;
    nd     = 0;
    for (int c = 0; c < 105; c++) begin
      start = 1'b1;
      data1 = 32'(100 + c);
      @(posedge clk); #1;
      if (done) begin
        if (nd < 3) begin
          res_q[nd]  = result;
          edge_q[nd] = c;
        end
        nd++;
      end
    end
    start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("held_done_count", 32'(nd), 32'd3);
    check("held_result0", res_q[0], 32'd300);
    check("held_result1", res_q[1], 32'd405);
    check("held_result2", res_q[2], 32'd510);
    check("held_done_edge0", 32'(edge_q[0]), 32'd33);
    check("held_done_edge1", 32'(edge_q[1]), 32'd68);
    check("held_done_edge2", 32'(edge_q[2]), 32'd103);

    // A START pulse during CALC must not disturb the running DIVU 100/7.
    funct3 = 3'b101;
    data1  = 32'd100;
    data2  = 32'd7;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    start  = 1'b1;
    funct3 = 3'b000;
    data1  = 32'd5;
    data2  = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("midcalc_busy", 32'(busy), 32'd1);
    check("midcalc_result_held", result, 32'd510);
    n = 11;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("midcalc_result", result, 32'h0000_000E);
    check("midcalc_latency", 32'(n + 1), 32'd34);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("midcalc_no_extra_done", 32'(nd), 32'd0);

    // Abort DIV 100/7 with asynchronous reset once the counter reaches 15.
    funct3 = 3'b100;
    data1  = 32'd100;
    data2  = 32'd7;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'h0000_0000);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);

    run_op("div_100_7", 3'b100, 32'd100, 32'd7, 32'h0000_000E);
    run_op("rem_100_7", 3'b110, 32'd100, 32'd7, 32'h0000_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
